// File: rtl/sound_scheduler_pkg.sv
// Shared definitions for the sound scheduler: tone codes, FSM states and
// default tone/gap durations (in slowen ticks).
package sound_scheduler_pkg;

   localparam int unsigned TONE_W = 3;
   localparam int unsigned NREQ   = 5;

   // Tone codes double as priority: a larger code wins.
   typedef enum logic [TONE_W-1:0] {
      TONE_NONE   = 3'd0,
      TONE_PUSH   = 3'd1,
      TONE_SPDRND = 3'd2,
      TONE_SPDWIN = 3'd3,
      TONE_RND    = 3'd4,
      TONE_GAME   = 3'd5
   } tone_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_e;

   localparam int unsigned DEF_CNT_W      = 8;
   localparam int unsigned DEF_DUR_GAME   = 64;
   localparam int unsigned DEF_DUR_RND    = 32;
   localparam int unsigned DEF_DUR_SPDWIN = 32;
   localparam int unsigned DEF_DUR_SPDRND = 16;
   localparam int unsigned DEF_DUR_PUSH   = 2;
   localparam int unsigned DEF_GAP_TICKS  = 4;

   // Win sounds play loud, everything else quiet.
   function automatic logic gain_for(tone_e t);
      return (t == TONE_GAME) || (t == TONE_RND);
   endfunction

endpackage

// File: rtl/sound_prio_enc.sv
// Combinational priority encoder over the pending request vector.
// Ports:
//   req   in  5  pending bits, bit0=push .. bit4=wingame
//   valid out 1  any bit set
//   code  out 3  tone code of the highest set bit (bit index + 1), 0 if none
//   clr   out 5  one-hot mask of the winning bit
module sound_prio_enc
   import sound_scheduler_pkg::*;
(
   input  logic [NREQ-1:0]   req,
   output logic              valid,
   output logic [TONE_W-1:0] code,
   output logic [NREQ-1:0]   clr
);

   // Ascending scan: the last set bit seen is the highest priority one.
   always_comb begin
      valid = |req;
      code  = '0;
      clr   = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (req[i]) begin
            code   = TONE_W'(i + 1);
            clr    = '0;
            clr[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sound_scheduler.sv
// Arbitrates one-cycle sound requests onto the single tone generator.
// Requests latch into a pending vector and are played one at a time in
// priority order, each tone followed by an optional silent gap, all timed
// in slowen ticks.
// Ports:
//   clk, rst (async, active-low)
//   slowen                         timing tick
//   sypush, speed_round, winspeed,
//   winrnd, wingame                request pulses
//   tone_sel[2:0], tone_en, gain,
//   notshutdown, busy              registered generator controls / status
module sound_scheduler
   import sound_scheduler_pkg::*;
#(
   parameter int unsigned CNT_W      = DEF_CNT_W,
   parameter int unsigned DUR_GAME   = DEF_DUR_GAME,
   parameter int unsigned DUR_RND    = DEF_DUR_RND,
   parameter int unsigned DUR_SPDWIN = DEF_DUR_SPDWIN,
   parameter int unsigned DUR_SPDRND = DEF_DUR_SPDRND,
   parameter int unsigned DUR_PUSH   = DEF_DUR_PUSH,
   parameter int unsigned GAP_TICKS  = DEF_GAP_TICKS,
   parameter int unsigned PREEMPT    = 1
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       slowen,
   input  logic       sypush,
   input  logic       speed_round,
   input  logic       winspeed,
   input  logic       winrnd,
   input  logic       wingame,
   output logic [2:0] tone_sel,
   output logic       tone_en,
   output logic       gain,
   output logic       notshutdown,
   output logic       busy
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_TICKS);

   state_e              state_q, state_d;
   logic [NREQ-1:0]     pend_q, pend_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   tone_e               sel_q, sel_d;
   logic                en_q, en_d;
   logic                gain_q, gain_d;
   logic                nsd_q, nsd_d;
   logic                busy_q, busy_d;

   logic [NREQ-1:0]     req;
   logic                enc_valid;
   logic [TONE_W-1:0]   enc_code;
   logic [NREQ-1:0]     enc_clr;
   logic                grant;
   logic                go_idle;

   assign req = {wingame, winrnd, winspeed, speed_round, sypush};

   sound_prio_enc u_enc (
      .req   (pend_q),
      .valid (enc_valid),
      .code  (enc_code),
      .clr   (enc_clr)
   );

   // Tone length for a code; a zero duration still plays for one tick.
   function automatic logic [CNT_W-1:0] dur_of(tone_e t);
      int unsigned d;
      case (t)
         TONE_GAME:   d = DUR_GAME;
         TONE_RND:    d = DUR_RND;
         TONE_SPDWIN: d = DUR_SPDWIN;
         TONE_SPDRND: d = DUR_SPDRND;
         TONE_PUSH:   d = DUR_PUSH;
         default:     d = 1;
      endcase
      if (d == 0) d = 1;
      return CNT_W'(d);
   endfunction

   // Next-state and output logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      en_d    = en_q;
      gain_d  = gain_q;
      nsd_d   = nsd_q;
      grant   = 1'b0;
      go_idle = 1'b0;

      case (state_q)
         IDLE: begin
            grant = enc_valid;
         end
         PLAY: begin
            if ((PREEMPT != 0) && enc_valid && (enc_code > sel_q)) begin
               grant = 1'b1;
            end else if (slowen) begin
               if (cnt_q == CNT_ONE) begin
                  if (GAP_TICKS == 0) begin
                     grant   = enc_valid;
                     go_idle = !enc_valid;
                  end else begin
                     state_d = GAP;
                     cnt_d   = GAP_LD;
                     sel_d   = TONE_NONE;
                     en_d    = 1'b0;
                     gain_d  = 1'b0;
                     nsd_d   = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
         end
         GAP: begin
            if (slowen) begin
               if (cnt_q == CNT_ONE) begin
                  grant   = enc_valid;
                  go_idle = !enc_valid;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
         end
         default: begin
            go_idle = 1'b1;
         end
      endcase

      if (grant) begin
         state_d = PLAY;
         sel_d   = tone_e'(enc_code);
         cnt_d   = dur_of(tone_e'(enc_code));
         en_d    = 1'b1;
         nsd_d   = 1'b1;
         gain_d  = gain_for(tone_e'(enc_code));
      end

      if (go_idle) begin
         state_d = IDLE;
         cnt_d   = '0;
         sel_d   = TONE_NONE;
         en_d    = 1'b0;
         gain_d  = 1'b0;
         nsd_d   = 1'b0;
      end

      // Clear before set so a request on its own grant edge stays pending.
      pend_d = (pend_q & ~(grant ? enc_clr : '0)) | req;
      busy_d = (state_d != IDLE) || (pend_d != '0);
   end

   // State, counter, pending and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pend_q  <= '0;
         cnt_q   <= '0;
         sel_q   <= TONE_NONE;
         en_q    <= 1'b0;
         gain_q  <= 1'b0;
         nsd_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         en_q    <= en_d;
         gain_q  <= gain_d;
         nsd_q   <= nsd_d;
         busy_q  <= busy_d;
      end
   end

   assign tone_sel    = sel_q;
   assign tone_en     = en_q;
   assign gain        = gain_q;
   assign notshutdown = nsd_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_sound_scheduler.sv
// Bench for sound_scheduler: three configurations (default, no preemption,
// zero gap with a zero-length push) share one stimulus stream and are compared
// every cycle against a tick-counting behavioural model.
module tb_sound_scheduler;

   localparam int NM = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic slowen = 1'b0;
   logic sypush = 1'b0, speed_round = 1'b0, winspeed = 1'b0;
   logic winrnd = 1'b0, wingame = 1'b0;

   logic [2:0] sel [NM];
   logic       en  [NM];
   logic       gn  [NM];
   logic       nsd [NM];
   logic       bsy [NM];

   int checks = 0;
   int errors = 0;
   int slow_mode = 0;
   int cyc_n = 0;
   int plays1 = 0, plays4 = 0;
   logic [2:0] prev0 = 3'd0;

   always #5 clk = ~clk;

   sound_scheduler u_dut0 (
      .clk(clk), .rst(rst), .slowen(slowen), .sypush(sypush),
      .speed_round(speed_round), .winspeed(winspeed), .winrnd(winrnd),
      .wingame(wingame), .tone_sel(sel[0]), .tone_en(en[0]), .gain(gn[0]),
      .notshutdown(nsd[0]), .busy(bsy[0]));

   sound_scheduler #(.PREEMPT(0)) u_dut1 (
      .clk(clk), .rst(rst), .slowen(slowen), .sypush(sypush),
      .speed_round(speed_round), .winspeed(winspeed), .winrnd(winrnd),
      .wingame(wingame), .tone_sel(sel[1]), .tone_en(en[1]), .gain(gn[1]),
      .notshutdown(nsd[1]), .busy(bsy[1]));

   sound_scheduler #(.GAP_TICKS(0), .DUR_PUSH(0), .DUR_GAME(3), .PREEMPT(1)) u_dut2 (
      .clk(clk), .rst(rst), .slowen(slowen), .sypush(sypush),
      .speed_round(speed_round), .winspeed(winspeed), .winrnd(winrnd),
      .wingame(wingame), .tone_sel(sel[2]), .tone_en(en[2]), .gain(gn[2]),
      .notshutdown(nsd[2]), .busy(bsy[2]));

   // ---------------- reference model ----------------
   int m_pre [NM] = '{1, 0, 1};
   int m_gap [NM] = '{4, 4, 0};

   bit [4:0] mp    [NM];   // pending sounds, bit0=push .. bit4=wingame
   int       mph   [NM];   // 0 silent, 1 tone, 2 gap
   int       mcur  [NM];   // sound currently audible
   int       mtick [NM];   // ticks elapsed in the current phase
   int       mlen  [NM];   // ticks the current phase lasts

   function automatic int dur_of(input int m, input int code);
      int d;
      case (code)
         5: d = (m == 2) ? 3 : 64;
         4: d = 32;
         3: d = 32;
         2: d = 16;
         1: d = (m == 2) ? 0 : 2;
         default: d = 1;
      endcase
      return (d == 0) ? 1 : d;
   endfunction

   task automatic model_step(input int m, input bit [4:0] r, input bit s);
      int top;
      bit g;
      bit idl;
      top = 0;
      for (int i = 0; i < 5; i++) if (mp[m][i]) top = i + 1;
      g   = 1'b0;
      idl = 1'b0;
      case (mph[m])
         0: g = (top != 0);
         1: begin
            if (m_pre[m] != 0 && top > mcur[m]) g = 1'b1;
            else if (s) begin
               mtick[m]++;
               if (mtick[m] >= mlen[m]) begin
                  if (m_gap[m] == 0) begin
                     g = (top != 0);
                     idl = !g;
                  end else begin
                     mph[m] = 2;
                     mtick[m] = 0;
                     mlen[m] = m_gap[m];
                  end
               end
            end
         end
         default: begin
            if (s) begin
               mtick[m]++;
               if (mtick[m] >= mlen[m]) begin
                  g = (top != 0);
                  idl = !g;
               end
            end
         end
      endcase
      if (g) begin
         mp[m][top-1] = 1'b0;
         mcur[m]  = top;
         mtick[m] = 0;
         mlen[m]  = dur_of(m, top);
         mph[m]   = 1;
      end
      if (idl) begin
         mph[m]  = 0;
         mcur[m] = 0;
      end
      mp[m] = mp[m] | r;
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int m = 0; m < NM; m++) begin
            mp[m] = '0; mph[m] = 0; mcur[m] = 0; mtick[m] = 0; mlen[m] = 0;
         end
      end else begin
         for (int m = 0; m < NM; m++)
            model_step(m, {wingame, winrnd, winspeed, speed_round, sypush}, slowen);
      end
   end

   // Count starts of push / winrnd tones on the default instance.
   always @(negedge clk) begin
      if (sel[0] == 3'd1 && prev0 != 3'd1) plays1++;
      if (sel[0] == 3'd4 && prev0 != 3'd4) plays4++;
      prev0 = sel[0];
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic compare_all();
      for (int m = 0; m < NM; m++) begin
         check_eq($sformatf("m%0d tone_sel", m), 32'(sel[m]), (mph[m] == 1) ? mcur[m] : 0);
         check_eq($sformatf("m%0d tone_en", m), 32'(en[m]), (mph[m] == 1) ? 1 : 0);
         check_eq($sformatf("m%0d gain", m), 32'(gn[m]), (mph[m] == 1 && mcur[m] >= 4) ? 1 : 0);
         check_eq($sformatf("m%0d notshutdown", m), 32'(nsd[m]), (mph[m] != 0) ? 1 : 0);
         check_eq($sformatf("m%0d busy", m), 32'(bsy[m]), (mph[m] != 0 || mp[m] != 0) ? 1 : 0);
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int m = 0; m < NM; m++) begin
         check_eq($sformatf("%s m%0d tone_sel", tag, m), 32'(sel[m]), 0);
         check_eq($sformatf("%s m%0d tone_en", tag, m), 32'(en[m]), 0);
         check_eq($sformatf("%s m%0d gain", tag, m), 32'(gn[m]), 0);
         check_eq($sformatf("%s m%0d notshutdown", tag, m), 32'(nsd[m]), 0);
         check_eq($sformatf("%s m%0d busy", tag, m), 32'(bsy[m]), 0);
      end
   endtask

   // Drive one cycle of requests (from a negedge), then compare at the next negedge.
   task automatic cyc(input logic [4:0] r);
      {wingame, winrnd, winspeed, speed_round, sypush} = r;
      if (slow_mode == 0) slowen = (cyc_n % 4 == 3);
      else slowen = ($urandom_range(2) == 0);
      cyc_n++;
      @(negedge clk);
      if (rst) compare_all();
   endtask

   task automatic drain(input int maxc);
      int n;
      n = 0;
      while ((bsy[0] || bsy[1] || bsy[2]) && n < maxc) begin
         cyc(5'd0);
         n++;
      end
      check_eq("drain_idle", 32'(bsy[0] | bsy[1] | bsy[2]), 0);
      repeat (3) cyc(5'd0);
   endtask

   task automatic async_reset(input string tag);
      {wingame, winrnd, winspeed, speed_round, sypush} = 5'd0;
      #2 rst = 1'b0;
      #1 check_all_zero(tag);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int p;
      logic [4:0] r;

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;
      repeat (2) cyc(5'd0);

      // Single push: pending then tone on the next edge.
      cyc(5'b00001);
      check_eq("push_pending_busy", 32'(bsy[0]), 1);
      check_eq("push_pending_en", 32'(en[0]), 0);
      cyc(5'd0);
      check_eq("push_sel", 32'(sel[0]), 1);
      check_eq("push_en", 32'(en[0]), 1);
      check_eq("push_gain", 32'(gn[0]), 0);
      drain(3000);

      // winspeed + speed_round together: winspeed first.
      cyc(5'b00110);
      cyc(5'd0);
      check_eq("pair_first_sel", 32'(sel[0]), 3);
      drain(3000);

      // wingame preempts a playing push (default), waits without preemption.
      p = plays1;
      cyc(5'b00001);
      cyc(5'd0);
      cyc(5'b10000);
      cyc(5'd0);
      check_eq("preempt_sel", 32'(sel[0]), 5);
      check_eq("preempt_gain", 32'(gn[0]), 1);
      check_eq("nopreempt_sel", 32'(sel[1]), 1);
      drain(3000);
      check_eq("push_not_replayed", 32'(plays1 - p), 1);

      // winrnd pulsed three times while pending behind wingame: one play.
      cyc(5'b10000);
      cyc(5'd0);
      p = plays4;
      cyc(5'b01000);
      cyc(5'd0);
      cyc(5'b01000);
      cyc(5'd0);
      cyc(5'b01000);
      drain(3000);
      check_eq("winrnd_collapse", 32'(plays4 - p), 1);

      // winrnd pulsed again on its grant edge: plays twice.
      p = plays4;
      cyc(5'b01000);
      cyc(5'b01000);
      drain(3000);
      check_eq("winrnd_grant_edge", 32'(plays4 - p), 2);

      // Randomized traffic with occasional async resets.
      slow_mode = 1;
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < 5; b++) r[b] = ($urandom_range(11) == 0);
         if ($urandom_range(399) == 0) async_reset("rand_reset");
         else cyc(r);
      end
      drain(3000);

      // Reset in the middle of a wingame tone.
      slow_mode = 0;
      cyc(5'b10000);
      repeat (10) cyc(5'd0);
      check_eq("midtone_sel", 32'(sel[0]), 5);
      @(posedge clk);
      async_reset("midtone_reset");
      repeat (20) cyc(5'd0);
      check_eq("after_reset_en", 32'(en[0]), 0);
      check_eq("after_reset_busy", 32'(bsy[0]), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sound_scheduler.md
Name: sound_scheduler

Overview:
- Arbitrates the game's sound-event requests (push, speed-round start, speed win, round win, game win) onto the single SoundController tone generator.
- Latches each one-cycle request, then plays requests one at a time in priority order.
- Times each tone and the silent gap between tones in slowen ticks from div256.
- Drives the generator's tone select, enable, gain and notshutdown.

Parameters:
- CNT_W, 8, width of the duration counter.
- DUR_GAME, 64, wingame tone length in slowen ticks.
- DUR_RND, 32, winrnd tone length in slowen ticks.
- DUR_SPDWIN, 32, winspeed tone length in slowen ticks.
- DUR_SPDRND, 16, speed_round tone length in slowen ticks.
- DUR_PUSH, 2, sypush click length in slowen ticks.
- GAP_TICKS, 4, silence between tones in slowen ticks; 0 means no gap.
- PREEMPT, 1, 1 lets a strictly higher-priority request abort the current tone.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- slowen  in  1  one-cycle tick from div256.
- sypush  in  1  push request pulse.
- speed_round  in  1  speed-round-start request pulse.
- winspeed  in  1  speed-win request pulse.
- winrnd  in  1  round-win request pulse.
- wingame  in  1  game-win request pulse.
- tone_sel  out  3  0=none, 1=push, 2=speed_round, 3=winspeed, 4=winrnd, 5=wingame.
- tone_en  out  1  generator enable.
- gain  out  1  1 = loud.
- notshutdown  out  1  amplifier on.
- busy  out  1  FSM not IDLE, or any request pending.

Behaviour:
- All outputs registered. While rst=0: tone_sel=0, tone_en=0, gain=0, notshutdown=0, busy=0, pending=0, counter=0, state=IDLE.
- Reset asserted mid-tone clears everything immediately, including pending requests.
- pending[4:0]: a bit sets on any clk edge where its request input is high. Inputs need not be held.
- Priority: wingame > winrnd > winspeed > speed_round > sypush.
- IDLE -> PLAY: on the edge after pending!=0.
  - Grant the highest-priority pending bit and clear that bit.
  - Load the counter with that sound's DUR (a DUR of 0 is treated as 1).
  - Set tone_sel to the sound's code; set tone_en=1 and notshutdown=1.
  - gain=1 for wingame/winrnd, 0 otherwise.
- Latency: a request sampled at edge k sets pending at k; tone_en=1 from edge k+1.
- PLAY: the counter decrements on each slowen.
  - When counter==1 and slowen=1: go to GAP, with tone_en=0, tone_sel=0, gain=0, notshutdown=1, counter=GAP_TICKS.
  - If GAP_TICKS=0, go straight to IDLE instead (or re-grant on that edge if anything is pending).
  - Tone duration is exactly DUR slowen ticks; slowen in the grant cycle itself is not counted.
- GAP: counter decrements on slowen; exits at counter==1 with slowen.
  - If pending!=0, go back to PLAY with a new grant on that edge.
  - Otherwise go to IDLE, with notshutdown=0 and busy=0 on the following cycle unless a new request arrives.
- Preemption (PREEMPT=1, PLAY only): if pending holds a strictly higher priority than the current tone_sel, regrant on the next edge.
  - Applies the new tone_sel and gain, reloads the counter, and clears that pending bit.
  - The aborted tone is dropped, not re-queued.
  - No preemption during GAP.
- Same-edge collisions:
  - A request and the grant of the same bit on one edge: the bit stays set, so the sound replays later.
  - Multiple requests on one edge: all latch.
  - A repeated request for an already-pending sound collapses to one play.
- The counter never wraps: it holds at 1 until slowen.

Decomposition:
- Shared package holds:
  - tone codes TONE_NONE..TONE_GAME (3-bit);
  - state encoding IDLE/PLAY/GAP;
  - the default duration constants.
- One sub-module, sound_prio_enc: a combinational 5-bit priority encoder producing valid, a 3-bit code and a one-hot clear mask. It is shared by the grant logic and the preemption compare.

Test Plan:
- Reset while PLAY wingame:
  - stimulus: drive rst=0 mid-tone.
  - expect: all outputs 0 the same cycle, asynchronously; pending empty after rst=1, and no tone plays.
- Single sypush pulse, slowen every 4 clks, DUR_PUSH=2, GAP_TICKS=4:
  - expect: tone_en=1, tone_sel=1, gain=0 from edge k+1 for exactly 2 slowen ticks.
  - then: 4 ticks with notshutdown=1 and tone_en=0, then IDLE with busy=0.
- winspeed and speed_round on the same edge:
  - expect: tone_sel=3 for 32 ticks, gap, then tone_sel=2 for 16 ticks.
- sypush playing, then wingame pulse:
  - expect: next edge tone_sel=5, gain=1, counter reloaded to 64; push not replayed.
- Same wingame scenario with PREEMPT=0:
  - expect: push completes, gap, then wingame plays.
- winrnd pulsed 3 times while winrnd is pending:
  - expect: one play.
- winrnd pulsed on its grant edge:
  - expect: a second winrnd play after the gap.
